// File: rtl/rx_fifo_ctrl_if.sv
// Bundle between rcv_block, the rx FIFO controller and the host-side byte consumer.
// Optional RX_ERR_TAG_EN adds rd_ferr, the framing-error tag of the head entry.
interface rx_fifo_ctrl_if #(
   parameter int ADDR_W = 3
);
   // Handshakes: data_ready is a level held by rcv_block until it sees the one-cycle
   // data_read pulse; rd_valid means rd_data is the head byte, and pop consumes it on
   // the rising edge (a pop while rd_valid=0 is ignored).
   logic [7:0]      rx_data;
   logic            data_ready;
   logic            overrun_error;
   logic            framing_error;
   logic            data_read;
   logic            pop;
   logic [7:0]      rd_data;
   logic            rd_valid;
`ifdef RX_ERR_TAG_EN
   logic            rd_ferr;
`endif
   logic            fifo_full;
   logic [ADDR_W:0] fifo_count;
   logic [7:0]      ovr_count;
   logic [7:0]      ferr_count;

   modport master (
`ifdef RX_ERR_TAG_EN
      input  rd_ferr,
`endif
      output rx_data, data_ready, overrun_error, framing_error, pop,
      input  data_read, rd_data, rd_valid, fifo_full, fifo_count, ovr_count, ferr_count
   );

   modport slave (
`ifdef RX_ERR_TAG_EN
      output rd_ferr,
`endif
      input  rx_data, data_ready, overrun_error, framing_error, pop,
      output data_read, rd_data, rd_valid, fifo_full, fifo_count, ovr_count, ferr_count
   );
endinterface

// File: rtl/rx_fifo_ctrl.sv
// Drains rcv_block into a DEPTH-entry FIFO, acknowledges each byte and counts error events.
// Define RX_ERR_TAG_EN to queue framing-error bytes with a tag instead of dropping them.
module rx_fifo_ctrl #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic         clk,
   input  logic         rst,
   rx_fifo_ctrl_if.slave bus,
   output logic [1:0]   state_dbg
);

`ifdef RX_ERR_TAG_EN
   localparam int W = 9;
`else
   localparam int W = 8;
`endif
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, HOLD, ACK, WAIT} state_t;

   state_t            state;
   logic              data_read_q;
   logic [W-1:0]      mem [DEPTH];
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W:0]   count;
   logic              ovr_prev;
   logic [7:0]        ovr_cnt;
   logic [7:0]        ferr_cnt;

   logic              space;
   logic              capture;
   logic              push;
   logic              pop_eff;

   // A pop on the same edge frees the slot, so a full FIFO can still accept a byte.
   always_comb begin
      space   = (count != FULL_CNT) | bus.pop;
      capture = space & (((state == IDLE) & bus.data_ready) | (state == HOLD));
      pop_eff = bus.pop & (count != '0);
`ifdef RX_ERR_TAG_EN
      push    = capture;
`else
      push    = capture & ~bus.framing_error;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         data_read_q <= 1'b0;
      end else begin
         data_read_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.data_ready) begin
                  if (space) begin
                     state       <= ACK;
                     data_read_q <= 1'b1;
                  end else begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (space) begin
                  state       <= ACK;
                  data_read_q <= 1'b1;
               end
            end
            ACK:  state <= WAIT;
            // Wait for rcv_block to drop data_ready so one byte is never captured twice.
            WAIT: if (!bus.data_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)    wptr <= wptr + 1'b1;
         if (pop_eff) rptr <= rptr + 1'b1;
         case ({push, pop_eff})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
`ifdef RX_ERR_TAG_EN
         mem[wptr] <= {bus.framing_error, bus.rx_data};
`else
         mem[wptr] <= bus.rx_data;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr_prev <= 1'b0;
         ovr_cnt  <= '0;
         ferr_cnt <= '0;
      end else begin
         ovr_prev <= bus.overrun_error;
         if (bus.overrun_error && !ovr_prev && ovr_cnt != 8'hFF)
            ovr_cnt <= ovr_cnt + 1'b1;
         if (capture && bus.framing_error && ferr_cnt != 8'hFF)
            ferr_cnt <= ferr_cnt + 1'b1;
      end
   end

   assign bus.data_read  = data_read_q;
   assign bus.rd_data    = mem[rptr][7:0];
`ifdef RX_ERR_TAG_EN
   assign bus.rd_ferr    = mem[rptr][8];
`endif
   assign bus.rd_valid   = (count != '0);
   assign bus.fifo_full  = (count == FULL_CNT);
   assign bus.fifo_count = count;
   assign bus.ovr_count  = ovr_cnt;
   assign bus.ferr_count = ferr_cnt;
   assign state_dbg      = state;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Self-checking bench for rx_fifo_ctrl: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_rx_fifo_ctrl;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
`ifdef RX_ERR_TAG_EN
   localparam bit TAG = 1'b1;
`else
   localparam bit TAG = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [1:0] state_dbg;

   rx_fifo_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   rx_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_ferr = 0;
   logic [8:0] exp_q[$];

   typedef struct {
      logic       is_pop;
      logic [7:0] data;
      int         exp_count;
      logic       exp_valid;
      logic [7:0] exp_head;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
      exp_ferr = 0;
   endtask

   // driver: behaves as rcv_block, holding data_ready until acknowledged
   task automatic send_byte(input logic [7:0] d, input logic fe);
      bit acked;
      acked = 1'b0;
      bus.rx_data       = d;
      bus.framing_error = fe;
      bus.data_ready    = 1'b1;
      for (int i = 0; i < 20 && !acked; i++) begin
         tick();
         if (bus.data_read) acked = 1'b1;
      end
      chk("ack_seen", 32'(acked), 32'd1);
      bus.data_ready = 1'b0;
      tick();
      chk("ack_one_cycle", 32'(bus.data_read), 32'd0);
      tick();
      bus.framing_error = 1'b0;
      if (acked) begin
         if (fe && exp_ferr < 255) exp_ferr++;
         if (TAG || !fe) exp_q.push_back({fe, d});
      end
   endtask

   task automatic pop_op();
      logic [8:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rd_valid", 32'(bus.rd_valid), 32'd1);
         chk("rd_data", 32'(bus.rd_data), 32'(e[7:0]));
`ifdef RX_ERR_TAG_EN
         chk("rd_ferr", 32'(bus.rd_ferr), 32'(e[8]));
`endif
      end else begin
         chk("rd_valid_empty", 32'(bus.rd_valid), 32'd0);
      end
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      chk("count_after_pop", 32'(bus.fifo_count), 32'(exp_q.size()));
   endtask

   initial begin
      rst               = 1'b0;
      bus.rx_data       = '0;
      bus.data_ready    = 1'b0;
      bus.overrun_error = 1'b0;
      bus.framing_error = 1'b0;
      bus.pop           = 1'b0;

      vecs[0] = '{1'b0, 8'hA5, 1, 1'b1, 8'hA5};
      vecs[1] = '{1'b0, 8'h5A, 2, 1'b1, 8'hA5};
      vecs[2] = '{1'b1, 8'h00, 1, 1'b1, 8'h5A};
      vecs[3] = '{1'b0, 8'hFF, 2, 1'b1, 8'h5A};
      vecs[4] = '{1'b1, 8'h00, 1, 1'b1, 8'hFF};
      vecs[5] = '{1'b1, 8'h00, 0, 1'b0, 8'h00};
      vecs[6] = '{1'b1, 8'h00, 0, 1'b0, 8'h00};
      vecs[7] = '{1'b0, 8'h00, 1, 1'b1, 8'h00};
      vecs[8] = '{1'b1, 8'h00, 0, 1'b0, 8'h00};

      // asynchronous reset values, no clock edge needed
      #1 rst = 1'b1;
      #1;
      chk("rst_data_read", 32'(bus.data_read), 32'd0);
      chk("rst_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_full", 32'(bus.fifo_full), 32'd0);
      chk("rst_ovr", 32'(bus.ovr_count), 32'd0);
      chk("rst_ferr", 32'(bus.ferr_count), 32'd0);
      do_reset();

      // single byte latency: captured on the first edge, ack and valid right after it
      bus.rx_data    = 8'hA5;
      bus.data_ready = 1'b1;
      tick();
      chk("lat_data_read", 32'(bus.data_read), 32'd1);
      chk("lat_rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("lat_rd_data", 32'(bus.rd_data), 32'hA5);
      chk("lat_count", 32'(bus.fifo_count), 32'd1);
      bus.data_ready = 1'b0;
      tick();
      chk("lat_pulse_end", 32'(bus.data_read), 32'd0);
      tick();
      exp_q.push_back(9'h0A5);
      pop_op();

      // vector table from empty
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].is_pop) pop_op();
         else send_byte(vecs[i].data, 1'b0);
         chk("vec_count", 32'(bus.fifo_count), 32'(vecs[i].exp_count));
         chk("vec_valid", 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) chk("vec_head", 32'(bus.rd_data), 32'(vecs[i].exp_head));
      end

      // fill, then a ninth byte must wait in HOLD until a pop frees a slot
      do_reset();
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
      chk("fill_full", 32'(bus.fifo_full), 32'd1);
      chk("fill_count", 32'(bus.fifo_count), 32'd8);
      bus.rx_data    = 8'h08;
      bus.data_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_no_ack", 32'(bus.data_read), 32'd0);
         chk("hold_count", 32'(bus.fifo_count), 32'd8);
      end
      chk("hold_head", 32'(bus.rd_data), 32'h00);
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      void'(exp_q.pop_front());
      chk("hold_release_ack", 32'(bus.data_read), 32'd1);
      chk("hold_release_count", 32'(bus.fifo_count), 32'd8);
      bus.data_ready = 1'b0;
      tick();
      tick();
      exp_q.push_back(9'h008);
      chk("hold_new_head", 32'(bus.rd_data), 32'h01);

      // full FIFO: pop and a new byte land on the same edge
      bus.rx_data    = 8'h09;
      bus.data_ready = 1'b1;
      bus.pop        = 1'b1;
      tick();
      bus.pop = 1'b0;
      void'(exp_q.pop_front());
      chk("pp_ack", 32'(bus.data_read), 32'd1);
      chk("pp_count", 32'(bus.fifo_count), 32'd8);
      chk("pp_full", 32'(bus.fifo_full), 32'd1);
      bus.data_ready = 1'b0;
      tick();
      tick();
      exp_q.push_back(9'h009);
      for (int i = 0; i < DEPTH; i++) begin
         chk("pp_order", 32'(bus.rd_data), 32'(i + 2));
         pop_op();
      end
      chk("pp_empty", 32'(bus.fifo_count), 32'd0);

      // framing error byte
      do_reset();
      send_byte(8'h3C, 1'b1);
      chk("ferr_count", 32'(bus.ferr_count), 32'd1);
`ifdef RX_ERR_TAG_EN
      chk("ferr_tag_count", 32'(bus.fifo_count), 32'd1);
      chk("ferr_tag", 32'(bus.rd_ferr), 32'd1);
      chk("ferr_tag_data", 32'(bus.rd_data), 32'h3C);
`else
      chk("ferr_drop_count", 32'(bus.fifo_count), 32'd0);
`endif

      // overrun rising edges and saturation
      for (int i = 0; i < 3; i++) begin
         bus.overrun_error = 1'b1;
         tick();
         bus.overrun_error = 1'b0;
         tick();
      end
      chk("ovr_3", 32'(bus.ovr_count), 32'd3);
      bus.overrun_error = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bus.overrun_error = 1'b0;
      tick();
      chk("ovr_level_once", 32'(bus.ovr_count), 32'd4);
      for (int i = 0; i < 296; i++) begin
         bus.overrun_error = 1'b1;
         tick();
         bus.overrun_error = 1'b0;
         tick();
      end
      chk("ovr_sat", 32'(bus.ovr_count), 32'd255);

      // reset asserted while in ACK, data_ready still high after release
      send_byte(8'h11, 1'b0);
      bus.rx_data    = 8'h77;
      bus.data_ready = 1'b1;
      tick();
      chk("pre_rst_ack", 32'(bus.data_read), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_data_read", 32'(bus.data_read), 32'd0);
      chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
      chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
      chk("mid_rst_ovr", 32'(bus.ovr_count), 32'd0);
      chk("mid_rst_ferr", 32'(bus.ferr_count), 32'd0);
      exp_q.delete();
      exp_ferr = 0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_ack", 32'(bus.data_read), 32'd1);
      chk("post_rst_count", 32'(bus.fifo_count), 32'd1);
      bus.data_ready = 1'b0;
      tick();
      tick();
      exp_q.push_back(9'h077);
      pop_op();

      // randomized traffic against the queue model
      do_reset();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) != 0 && exp_q.size() < DEPTH)
            send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
         else
            pop_op();
         chk("rand_count", 32'(bus.fifo_count), 32'(exp_q.size()));
         chk("rand_full", 32'(bus.fifo_full), 32'(exp_q.size() == DEPTH));
         chk("rand_ferr", 32'(bus.ferr_count), 32'(exp_ferr));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
